// File: rtl/alu_rs_pkg.sv
// Shared types for the integer ALU reservation station: ALU opcodes,
// entry layout, default sizing and the CDB capture helper.
package alu_rs_pkg;

  localparam int ALU_RS_DEPTH = 4;
  localparam int ALU_RS_TAG_W = 4;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SLL = 5'd1,
    ALU_SRA = 5'd2,
    ALU_SUB = 5'd3,
    ALU_XOR = 5'd4,
    ALU_SRL = 5'd5,
    ALU_OR  = 5'd6,
    ALU_AND = 5'd7
  } alu_ops;

  typedef struct packed {
    logic                    rdy;
    logic [31:0]             val;
    logic [ALU_RS_TAG_W-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                    valid;
    alu_ops                  aluop;
    logic [31:0]             pc;
    logic [ALU_RS_TAG_W-1:0] rob_tag;
    rs_src_t                 src1;
    rs_src_t                 src2;
  } rs_entry_t;

  // A waiting source whose producer tag is on the CDB becomes ready with
  // the broadcast value; a ready source is left untouched.
  function automatic rs_src_t capture_src(input rs_src_t                 src,
                                          input logic                    cdb_valid,
                                          input logic [ALU_RS_TAG_W-1:0] cdb_tag,
                                          input logic [31:0]             cdb_data);
    rs_src_t res;
    res = src;
    if (!src.rdy && cdb_valid && (cdb_tag == src.tag)) begin
      res.rdy = 1'b1;
      res.val = cdb_data;
    end else begin
      res = src;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch / CDB / issue / writeback bundle of the ALU reservation station.
// master = dispatch and core side, slave = the reservation station.
interface alu_rs_if #(parameter int TAG_W = 4);
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [4:0]        disp_aluop;
  logic [31:0]       disp_pc;
  logic [TAG_W-1:0]  disp_rob_tag;
  logic              disp_src1_rdy;
  logic              disp_src2_rdy;
  logic [31:0]       disp_src1_val;
  logic [31:0]       disp_src2_val;
  logic [TAG_W-1:0]  disp_src1_tag;
  logic [TAG_W-1:0]  disp_src2_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_data;
  logic              fu_stall;
  logic              alu_en;
  logic [4:0]        aluop;
  logic [31:0]       a;
  logic [31:0]       b;
  logic [31:0]       pc;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_rob_tag;

  modport master (
    output flush, disp_valid, disp_aluop, disp_pc, disp_rob_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag, cdb_valid, cdb_tag, cdb_data, fu_stall,
    input  disp_ready, alu_en, aluop, a, b, pc, wb_valid, wb_rob_tag
  );

  modport slave (
    input  flush, disp_valid, disp_aluop, disp_pc, disp_rob_tag,
           disp_src1_rdy, disp_src2_rdy, disp_src1_val, disp_src2_val,
           disp_src1_tag, disp_src2_tag, cdb_valid, cdb_tag, cdb_data, fu_stall,
    output disp_ready, alu_en, aluop, a, b, pc, wb_valid, wb_rob_tag
  );
endinterface

// File: rtl/alu_rs_age_matrix.sv
// Age matrix for oldest-first issue (used when ALU_RS_AGE_SELECT_EN is set).
// older_q[i][j] = 1 means entry i was dispatched before entry j. Bits of
// invalid entries may be stale; they are masked by the ready vector.
module alu_rs_age_matrix #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic [DEPTH-1:0]         valid_vec,
  input  logic [DEPTH-1:0]         dealloc_oh,
  input  logic [DEPTH-1:0]         ready_vec,
  output logic [DEPTH-1:0]         oldest_oh
);

  logic [DEPTH-1:0][DEPTH-1:0] older_q, older_d;

  // Oldest ready entry: ready and older than every other ready entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      oldest_oh[i] = ready_vec[i];
      for (int j = 0; j < DEPTH; j++) begin
        oldest_oh[i] = oldest_oh[i] & ((i == j) | ~ready_vec[j] | older_q[i][j]);
      end
    end
  end

  // New entry is younger than all currently valid ones; freed rows/columns clear.
  always_comb begin
    older_d = older_q;
    if (flush) begin
      older_d = '0;
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        older_d[j][alloc_idx] = alloc_en ? valid_vec[j] : older_d[j][alloc_idx];
        older_d[alloc_idx][j] = alloc_en ? 1'b0 : older_d[alloc_idx][j];
      end
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          older_d[i][j] = older_d[i][j] & ~dealloc_oh[i] & ~dealloc_oh[j];
        end
      end
    end
  end

  // Age state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else begin
      older_q <= older_d;
    end
  end

endmodule

// File: rtl/alu_rs.sv
// Integer ALU reservation station: holds dispatched ops until both sources
// are ready (CDB snoop with dispatch-cycle bypass), issues one per cycle and
// registers the issued ROB tag so writeback lines up with the ALU result.
// Build option: ALU_RS_AGE_SELECT_EN selects oldest-ready instead of
// lowest-index-ready issue.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int DEPTH = ALU_RS_DEPTH,
  parameter int TAG_W = ALU_RS_TAG_W
) (
  input  logic     clk,
  input  logic     rst,
  alu_rs_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_d [DEPTH];
  rs_entry_t        disp_entry;
  logic             wb_valid_q, wb_valid_d;
  logic [TAG_W-1:0] wb_rob_tag_q, wb_rob_tag_d;
  logic [DEPTH-1:0] free_vec;
  logic [DEPTH-1:0] ready_vec;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             any_free;
  logic             any_ready;
  logic             disp_fire;
  logic             issue_fire;

  // Free / ready status derived from registered entry state only.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_vec[i]  = ~entries_q[i].valid;
      ready_vec[i] = entries_q[i].valid & entries_q[i].src1.rdy & entries_q[i].src2.rdy;
    end
  end

  assign any_free   = |free_vec;
  assign any_ready  = |ready_vec;
  assign disp_fire  = bus.disp_valid & any_free & ~bus.flush;
  assign issue_fire = any_ready & ~bus.fu_stall & ~bus.flush;

  // Lowest-index free entry receives the dispatch.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_idx = free_vec[i] ? IDX_W'(i) : alloc_idx;
    end
  end

`ifdef ALU_RS_AGE_SELECT_EN
  logic [DEPTH-1:0] oldest_oh;
  logic [DEPTH-1:0] dealloc_oh;

  assign dealloc_oh = issue_fire ? oldest_oh : '0;

  alu_rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.flush),
    .alloc_en   (disp_fire),
    .alloc_idx  (alloc_idx),
    .valid_vec  (~free_vec),
    .dealloc_oh (dealloc_oh),
    .ready_vec  (ready_vec),
    .oldest_oh  (oldest_oh)
  );

  // One-hot oldest-ready to entry index.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_idx = oldest_oh[i] ? IDX_W'(i) : sel_idx;
    end
  end
`else
  // Fixed priority: lowest-index ready entry issues.
  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx = ready_vec[i] ? IDX_W'(i) : sel_idx;
    end
  end
`endif

  // Incoming entry, with same-cycle CDB bypass on waiting sources.
  always_comb begin
    disp_entry.valid   = 1'b1;
    disp_entry.aluop   = alu_ops'(bus.disp_aluop);
    disp_entry.pc      = bus.disp_pc;
    disp_entry.rob_tag = bus.disp_rob_tag;
    disp_entry.src1    = capture_src('{rdy: bus.disp_src1_rdy, val: bus.disp_src1_val,
                                       tag: bus.disp_src1_tag},
                                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    disp_entry.src2    = capture_src('{rdy: bus.disp_src2_rdy, val: bus.disp_src2_val,
                                       tag: bus.disp_src2_tag},
                                     bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  // Next entry state: flush clears, issue frees, CDB wakes, dispatch writes.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rs_entry_t held;
      held       = entries_q[i];
      held.src1  = capture_src(entries_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      held.src2  = capture_src(entries_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      held.valid = entries_q[i].valid & ~bus.flush &
                   ~(issue_fire & (sel_idx == IDX_W'(i)));
      entries_d[i] = (disp_fire && (alloc_idx == IDX_W'(i))) ? disp_entry : held;
    end
  end

  // Writeback tracking lines up with the ALU's registered result.
  always_comb begin
    wb_valid_d   = issue_fire;
    wb_rob_tag_d = issue_fire ? entries_q[sel_idx].rob_tag : wb_rob_tag_q;
  end

  // Entry and writeback registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wb_valid_q   <= 1'b0;
      wb_rob_tag_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      wb_valid_q   <= wb_valid_d;
      wb_rob_tag_q <= wb_rob_tag_d;
    end
  end

  assign bus.disp_ready = any_free;
  assign bus.alu_en     = issue_fire;
  assign bus.aluop      = entries_q[sel_idx].aluop;
  assign bus.a          = entries_q[sel_idx].src1.val;
  assign bus.b          = entries_q[sel_idx].src2.val;
  assign bus.pc         = entries_q[sel_idx].pc;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rob_tag = wb_rob_tag_q;

endmodule
